// File: rtl/glitch_free_div.sv
// Purpose : glitch-free programmable clock divider, ratio changes land on a rising edge of clk_out.
// Latency : clk_out first rises div_cur cycles after RUN entry; requests are acknowledged at the next 0->1 toggle.
// Backpressure: one outstanding ratio change; requests while busy or with H=0 are dropped with div_err.
module glitch_free_div #(
    parameter int DIV_W   = 4,
    parameter int RST_DIV = 1
) (
    input  logic             clk_in,
    input  logic             rst_clk,
    input  logic             clk_en,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_sel,
    input  logic             icg_scan_mode,
    output logic             clk_out,
    output logic [DIV_W-1:0] div_cur,
    output logic             div_busy,
    output logic             div_ack,
    output logic             div_err
);

    localparam logic [DIV_W-1:0] RST_H = DIV_W'(RST_DIV);

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] pend;
    logic [DIV_W-1:0] pend_nxt;
    logic [DIV_W-1:0] cur_nxt;
    logic             clk_q;
    logic             clk_nxt;
    logic             busy_nxt;
    logic             ack_nxt;
    logic             err_nxt;
    logic             at_end;

    // Last cycle of the current half-period.
    assign at_end = (cnt == (div_cur - DIV_W'(1)));

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_clk) begin
            state <= STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter, output clock, ratio and handshake registers.
    always_ff @(posedge clk_in) begin
        if (rst_clk) begin
            cnt      <= '0;
            clk_q    <= 1'b0;
            div_cur  <= RST_H;
            pend     <= RST_H;
            div_busy <= 1'b0;
            div_ack  <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            clk_q    <= clk_nxt;
            div_cur  <= cur_nxt;
            pend     <= pend_nxt;
            div_busy <= busy_nxt;
            div_ack  <= ack_nxt;
            div_err  <= err_nxt;
        end
    end

    // Next-state logic: request capture, half-period counting and stop/drain handling.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clk_nxt   = clk_q;
        cur_nxt   = div_cur;
        pend_nxt  = pend;
        busy_nxt  = div_busy;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;

        // Capture and apply are exclusive: capture needs !busy, apply needs busy.
        if (div_req) begin
            if (!div_busy && (div_sel != '0)) begin
                pend_nxt = div_sel;
                busy_nxt = 1'b1;
            end else begin
                err_nxt = 1'b1;
            end
        end

        case (state)
            STOP: begin
                cnt_nxt = '0;
                clk_nxt = 1'b0;
                if (clk_en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!clk_en && !clk_q) begin
                    // Low phase can be cut short safely: output is already low.
                    state_nxt = STOP;
                    cnt_nxt   = '0;
                end else if (at_end) begin
                    cnt_nxt = '0;
                    clk_nxt = !clk_q;
                    if (!clk_q) begin
                        // Rising toggle: only point where a new ratio may take effect.
                        if (div_busy) begin
                            cur_nxt  = pend;
                            ack_nxt  = 1'b1;
                            busy_nxt = 1'b0;
                        end
                    end else if (!clk_en) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + DIV_W'(1);
                    if (!clk_en) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // High phase runs to completion; only the falling toggle can occur here.
                if (at_end) begin
                    cnt_nxt   = '0;
                    clk_nxt   = 1'b0;
                    state_nxt = clk_en ? RUN : STOP;
                end else begin
                    cnt_nxt = cnt + DIV_W'(1);
                    if (clk_en) begin
                        state_nxt = RUN;
                    end
                end
            end
            default: begin
                state_nxt = STOP;
            end
        endcase
    end

    // Single output mux: scan bypass passes clk_in straight through.
    assign clk_out = icg_scan_mode ? clk_in : clk_q;

endmodule

// File: tb/tb_glitch_free_div.sv
// Directed bench for glitch_free_div with hand-traced expected waveforms.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
// Covers reset, ratio change, rejects, drain/stop, scan bypass and reset mid-change.
module tb_glitch_free_div;

    logic       clk_in = 1'b0;
    logic       rst_clk;
    logic       clk_en;
    logic       div_req;
    logic [3:0] div_sel;
    logic       icg_scan_mode;
    logic       clk_out;
    logic [3:0] div_cur;
    logic       div_busy;
    logic       div_ack;
    logic       div_err;

    int n_cmp = 0;
    int n_bad = 0;

    glitch_free_div #(.DIV_W(4), .RST_DIV(1)) dut (
        .clk_in        (clk_in),
        .rst_clk       (rst_clk),
        .clk_en        (clk_en),
        .div_req       (div_req),
        .div_sel       (div_sel),
        .icg_scan_mode (icg_scan_mode),
        .clk_out       (clk_out),
        .div_cur       (div_cur),
        .div_busy      (div_busy),
        .div_ack       (div_ack),
        .div_err       (div_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic tick_clk(input string tag, input logic exp);
        tick();
        chk(tag, {31'd0, clk_out}, {31'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_clk = 1'b1; clk_en = 1'b0; div_req = 1'b0; div_sel = 4'd0; icg_scan_mode = 1'b0;
        tick(); tick();
        rst_clk = 1'b0;
        tick();
        chk("rst_clk_out", {31'd0, clk_out}, 32'd0);
        chk("rst_div_cur", {28'd0, div_cur}, 32'd1);
        chk("rst_busy",    {31'd0, div_busy}, 32'd0);
        chk("rst_ack",     {31'd0, div_ack}, 32'd0);
        chk("rst_err",     {31'd0, div_err}, 32'd0);

        // H=1: period 2 after RUN entry
        clk_en = 1'b1;
        tick_clk("h1_e1", 1'b0);
        tick_clk("h1_e2", 1'b1);
        tick_clk("h1_e3", 1'b0);
        tick_clk("h1_e4", 1'b1);
        chk("h1_noack", {31'd0, div_ack | div_err}, 32'd0);

        // change to H=3
        div_req = 1'b1; div_sel = 4'd3;
        tick_clk("h3_e5", 1'b0);
        div_req = 1'b0;
        chk("h3_busy", {31'd0, div_busy}, 32'd1);
        chk("h3_cur_old", {28'd0, div_cur}, 32'd1);
        tick_clk("h3_e6", 1'b1);
        chk("h3_ack", {31'd0, div_ack}, 32'd1);
        chk("h3_cur_new", {28'd0, div_cur}, 32'd3);
        chk("h3_busy_clr", {31'd0, div_busy}, 32'd0);
        tick_clk("h3_e7", 1'b1);
        chk("h3_ack_pulse", {31'd0, div_ack}, 32'd0);
        tick_clk("h3_e8", 1'b1);
        tick_clk("h3_e9", 1'b0);
        tick_clk("h3_e10", 1'b0);
        tick_clk("h3_e11", 1'b0);
        tick_clk("h3_e12", 1'b1);

        // reject H=0, then reject a second request while busy
        div_req = 1'b1; div_sel = 4'd0;
        tick();
        chk("zero_err", {31'd0, div_err}, 32'd1);
        chk("zero_cur", {28'd0, div_cur}, 32'd3);
        chk("zero_busy", {31'd0, div_busy}, 32'd0);
        div_sel = 4'd2;
        tick();
        chk("acc_busy", {31'd0, div_busy}, 32'd1);
        chk("acc_err", {31'd0, div_err}, 32'd0);
        div_sel = 4'd5;
        tick_clk("busy_e15", 1'b0);
        div_req = 1'b0;
        chk("busy_err", {31'd0, div_err}, 32'd1);
        chk("busy_still", {31'd0, div_busy}, 32'd1);
        tick(); tick();
        tick_clk("h2_e18", 1'b1);
        chk("h2_ack", {31'd0, div_ack}, 32'd1);
        chk("h2_cur", {28'd0, div_cur}, 32'd2);
        tick_clk("h2_e19", 1'b1);
        tick_clk("h2_e20", 1'b0);

        // H=4, drop clk_en one cycle into the high phase
        div_req = 1'b1; div_sel = 4'd4;
        tick_clk("h4_e21", 1'b0);
        div_req = 1'b0;
        tick_clk("h4_e22", 1'b1);
        chk("h4_ack", {31'd0, div_ack}, 32'd1);
        chk("h4_cur", {28'd0, div_cur}, 32'd4);
        clk_en = 1'b0;
        tick_clk("drain_e23", 1'b1);
        tick_clk("drain_e24", 1'b1);
        tick_clk("drain_e25", 1'b1);
        tick_clk("drain_e26", 1'b0);
        tick_clk("stop_e27", 1'b0);
        tick_clk("stop_e28", 1'b0);
        clk_en = 1'b1;
        tick_clk("restart_e29", 1'b0);
        tick_clk("restart_e30", 1'b0);
        tick_clk("restart_e31", 1'b0);
        tick_clk("restart_e32", 1'b0);
        tick_clk("restart_e33", 1'b1);

        // scan bypass for 20 cycles
        icg_scan_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("scan_hi", {31'd0, clk_out}, 32'd1);
            @(negedge clk_in);
            #1;
            chk("scan_lo", {31'd0, clk_out}, 32'd0);
        end
        icg_scan_mode = 1'b0;
        #1;
        chk("scan_rel", {31'd0, clk_out}, 32'd0);
        tick_clk("post_e54", 1'b0);
        tick_clk("post_e55", 1'b0);
        tick_clk("post_e56", 1'b0);
        tick_clk("post_e57", 1'b1);

        // reset while draining with a pending change
        div_req = 1'b1; div_sel = 4'd2; clk_en = 1'b0;
        tick_clk("pre_rst_clk", 1'b1);
        div_req = 1'b0;
        chk("pre_rst_busy", {31'd0, div_busy}, 32'd1);
        rst_clk = 1'b1;
        tick();
        chk("mid_rst_clk", {31'd0, clk_out}, 32'd0);
        chk("mid_rst_cur", {28'd0, div_cur}, 32'd1);
        chk("mid_rst_busy", {31'd0, div_busy}, 32'd0);
        chk("mid_rst_ack", {31'd0, div_ack}, 32'd0);
        chk("mid_rst_err", {31'd0, div_err}, 32'd0);
        rst_clk = 1'b0;
        tick();
        chk("post_rst_ack", {31'd0, div_ack}, 32'd0);
        chk("post_rst_clk", {31'd0, clk_out}, 32'd0);

        // request equal to current H still acknowledged
        clk_en = 1'b1; div_req = 1'b1; div_sel = 4'd1;
        tick();
        div_req = 1'b0;
        chk("same_busy", {31'd0, div_busy}, 32'd1);
        tick_clk("same_rise", 1'b1);
        chk("same_ack", {31'd0, div_ack}, 32'd1);
        chk("same_cur", {28'd0, div_cur}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
